// File: rtl/unified_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unified_memory_pkg
//  Description : Shared encodings for the multi-channel unified memory model:
//                FSM state encoding, transfer op encoding, width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package unified_memory_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_memory_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. The search starts at the
//                channel after i_last and the first requester found wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import unified_memory_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_last,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_valid
);

    logic [CH_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester after i_last is the last (and therefore winning) assignment.
    always_comb begin
        o_grant = '0;
        o_valid = |i_req;
        w_idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CH_W'((int'(i_last) + k) % NUM_CH);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/unified_memory.sv
`default_nettype none
// ============================================================================
//  Module      : unified_memory
//  Description : Multi-channel block memory model shared by the instruction
//                and data caches. Round-robin arbitration, fixed access
//                latency, per-channel registered read data, and a
//                combinational per-channel busywait.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_memory
    import unified_memory_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int BLOCK_WIDTH = 128,
    parameter int ADDR_WIDTH  = 28,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = 5
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_CH-1:0]             READ,
    input  logic [NUM_CH-1:0]             WRITE,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]  ADDRESS,
    input  logic [NUM_CH*BLOCK_WIDTH-1:0] WRITEDATA,
    output logic [NUM_CH*BLOCK_WIDTH-1:0] READDATA,
    output logic [NUM_CH-1:0]             BUSYWAIT
);

    localparam int C_CH_W  = ch_width(NUM_CH);
    localparam int C_IDX_W = ch_width(DEPTH);
    localparam int C_CNT_W = ch_width(LATENCY);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(LATENCY - 1);

    // Backing store; deliberately not reset so preloaded contents survive.
    logic [BLOCK_WIDTH-1:0] MEM_ARRAY [0:DEPTH-1];

    logic [NUM_CH-1:0]             w_req;
    logic [C_CH_W-1:0]             w_arb_grant;
    logic                          w_arb_valid;
    mem_state_t                    r_state;
    mem_state_t                    w_next_state;
    logic                          w_grant_en;
    logic                          w_xfer;
    logic [C_CNT_W-1:0]            r_count;
    logic [C_CH_W-1:0]             r_last;
    logic [C_CH_W-1:0]             r_grant;
    logic                          r_op;
    logic [C_IDX_W-1:0]            r_index;
    logic [BLOCK_WIDTH-1:0]        r_wdata;
    logic [NUM_CH*BLOCK_WIDTH-1:0] r_readdata;
    logic                          w_unused_addr;

    assign w_req    = READ | WRITE;
    assign READDATA = r_readdata;

    // Address bits above the index only alias; they never select storage.
    assign w_unused_addr = ^ADDRESS;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (C_CH_W)
    ) u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_valid)
    );

    // A channel stalls while requesting, except in its own DONE cycle.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_busy
            assign BUSYWAIT[i] = w_req[i] &
                                 ~((r_state == MEM_DONE) && (r_grant == C_CH_W'(i)));
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; grants only from IDLE so a held request is not re-granted in DONE.
    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_en   = 1'b1;
                    w_next_state = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                if (r_count == '0) begin
                    w_xfer       = 1'b1;
                    w_next_state = MEM_DONE;
                end
            end
            MEM_DONE: begin
                w_next_state = MEM_IDLE;
            end
            default: begin
                w_next_state = MEM_IDLE;
            end
        endcase
    end

    // Capture the winning request at grant time and count down the access latency.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            r_last  <= C_CH_W'(NUM_CH - 1);
            r_grant <= '0;
            r_op    <= OP_READ;
            r_index <= '0;
            r_wdata <= '0;
        end else if (w_grant_en) begin
            r_grant <= w_arb_grant;
            r_last  <= w_arb_grant;
            r_op    <= WRITE[w_arb_grant] ? OP_WRITE : OP_READ;
            r_index <= ADDRESS[int'(w_arb_grant)*ADDR_WIDTH +: C_IDX_W];
            r_wdata <= WRITEDATA[int'(w_arb_grant)*BLOCK_WIDTH +: BLOCK_WIDTH];
            r_count <= C_CNT_INIT;
        end else if ((r_state == MEM_ACCESS) && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Read result lands in the granted channel's slot and holds until its next read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_readdata <= '0;
        end else if (w_xfer && (r_op == OP_READ)) begin
            r_readdata[int'(r_grant)*BLOCK_WIDTH +: BLOCK_WIDTH] <= MEM_ARRAY[r_index];
        end
    end

    // Memory write; an asserted reset drops any pending write.
    always_ff @(posedge CLK) begin
        if (!RESET && w_xfer && (r_op == OP_WRITE)) begin
            MEM_ARRAY[r_index] <= r_wdata;
        end
    end

endmodule
`default_nettype wire
